// File: rtl/int_event_scheduler_pkg.sv
// int_event_sched_pkg: shared types, width helpers and default parameters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: read-FSM state enum, calc_idw/calc_fw width helpers,
//           DEF_* default parameter values for the scheduler.
package int_event_sched_pkg;

  localparam int DEF_NUM_REQ          = 4;
  localparam int DEF_CODE_WIDTH       = 6;
  localparam int DEF_RD_LAT           = 2;
  localparam int DEF_COALESCE_TIMEOUT = 255;

  // Read-side FSM.
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_HOLD  = 2'd3
  } rd_state_e;

  // Requester index width.
  function automatic int calc_idw(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // FIFO word width: {requester index, event code}.
  function automatic int calc_fw(input int num_req, input int code_width);
    return code_width + calc_idw(num_req);
  endfunction

endpackage

// File: rtl/int_event_scheduler_if.sv
// int_event_scheduler_if: bundles requester, FIFO and host signals.
// Latency: n/a (wires only).
// Backpressure: fifo_full stalls writers; evt_valid/evt_pop hands events to the host.
// Modports: slave  = scheduler side (drives acks, FIFO strobes, host event, irq)
//           master = environment side (requesters, FIFO model, host).
interface int_event_scheduler_if
  import int_event_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CODE_WIDTH = DEF_CODE_WIDTH
);
  localparam int FW = calc_fw(NUM_REQ, CODE_WIDTH);

  // Requesters
  logic [NUM_REQ-1:0]            evt_req;
  logic [NUM_REQ*CODE_WIDTH-1:0] evt_code;
  logic [NUM_REQ-1:0]            evt_ack;
  // External FIFO
  logic                          fifo_wrEn;
  logic [FW-1:0]                 fifo_wrData;
  logic                          fifo_rdEn;
  logic [FW-1:0]                 fifo_rdData;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_wmark;
  // Host
  logic                          evt_valid;
  logic [FW-1:0]                 evt_data;
  logic                          evt_pop;
  logic                          irq;

  modport slave (
    input  evt_req, evt_code, fifo_rdData, fifo_full, fifo_empty, fifo_wmark, evt_pop,
    output evt_ack, fifo_wrEn, fifo_wrData, fifo_rdEn, evt_valid, evt_data, irq
  );

  modport master (
    output evt_req, evt_code, fifo_rdData, fifo_full, fifo_empty, fifo_wmark, evt_pop,
    input  evt_ack, fifo_wrEn, fifo_wrData, fifo_rdEn, evt_valid, evt_data, irq
  );

endinterface

// File: rtl/int_event_scheduler_rr_arbiter.sv
// int_rr_arbiter: round-robin one-hot grant with registered priority pointer.
// Latency: combinational grant from req_i and the registered pointer.
// Backpressure: enable_i low suppresses every grant and freezes the pointer.
// Ports: clock/reset (sync, active-high), req_i, enable_i,
//        grant_o (one-hot), grant_idx_o (binary), grant_vld_o.
module int_rr_arbiter
  import int_event_sched_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int IW = calc_idw(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_vld_o
);

  // ptr_q is the index with highest priority this cycle.
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  int            sel;
  logic          found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    ptr_d       = ptr_q;
    cand        = '0;
    sel         = 0;
    found       = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && enable_i && req_i[cand]) begin
        found = 1'b1;
        sel   = int'(cand);
      end
    end
    if (found) begin
      grant_o[IW'(sel)] = 1'b1;
      grant_idx_o       = IW'(sel);
      grant_vld_o       = 1'b1;
      // Next search starts just after the winner.
      ptr_d             = (sel == N - 1) ? '0 : IW'(sel + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/int_event_scheduler.sv
// int_event_scheduler: funnels requester events into an external FIFO and
// presents them one at a time to the host with a level interrupt.
// Latency: write combinational from the RR pointer; read evt_valid RD_LAT cycles after fifo_rdEn.
// Backpressure: fifo_full holds all acks low; an unpopped host event blocks further FIFO reads.
// Ports: clock, reset (sync, active-high), bus (int_event_scheduler_if.slave).
// Optional feature: define INT_COALESCE_EN for watermark/timer interrupt coalescing.
module int_event_scheduler
  import int_event_sched_pkg::*;
#(
  parameter int NUM_REQ          = DEF_NUM_REQ,
  parameter int CODE_WIDTH       = DEF_CODE_WIDTH,
  parameter int RD_LAT           = DEF_RD_LAT,
  parameter int COALESCE_TIMEOUT = DEF_COALESCE_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  int_event_scheduler_if.slave  bus
);

  localparam int IDW = calc_idw(NUM_REQ);
  localparam int FW  = calc_fw(NUM_REQ, CODE_WIDTH);
  localparam int WCW = 2;

  // ---------------- write side ----------------
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_vld;
  logic [CODE_WIDTH-1:0] codes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_codes
    assign codes[g] = bus.evt_code[g*CODE_WIDTH +: CODE_WIDTH];
  end

  // Reset gates the enable so no ack/write leaks out while reset is held.
  int_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req_i       (bus.evt_req),
    .enable_i    (!bus.fifo_full && !reset),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign bus.evt_ack     = grant;
  assign bus.fifo_wrEn   = grant_vld;
  assign bus.fifo_wrData = {grant_idx, codes[grant_idx]};

  // ---------------- read side ----------------
  // fifo_rdData is sampled on the RD_LAT-th rising edge after the edge that
  // raises fifo_rdEn, so evt_valid rises RD_LAT cycles after the rdEn cycle
  // (RD_LAT=2 suits a FIFO with one output register, RD_LAT=1 a show-ahead one).
  rd_state_e      state_q;
  logic           rd_en_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           evt_valid_q;
  logic [FW-1:0]  evt_data_q;
  logic           irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RD_IDLE;
      rd_en_q     <= 1'b0;
      wait_cnt_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (!bus.fifo_empty && !evt_valid_q) begin
            state_q <= RD_ISSUE;
            rd_en_q <= 1'b1;
          end
        end
        RD_ISSUE: begin
          rd_en_q <= 1'b0;
          if (RD_LAT <= 1) begin
            evt_data_q  <= bus.fifo_rdData;
            evt_valid_q <= 1'b1;
            state_q     <= RD_HOLD;
          end else begin
            wait_cnt_q <= WCW'(RD_LAT - 2);
            state_q    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt_q == '0) begin
            evt_data_q  <= bus.fifo_rdData;
            evt_valid_q <= 1'b1;
            state_q     <= RD_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        RD_HOLD: begin
          if (bus.evt_pop) begin
            evt_valid_q <= 1'b0;
            state_q     <= RD_IDLE;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign bus.fifo_rdEn = rd_en_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_data  = evt_data_q;
  assign bus.irq       = irq_q;

  // ---------------- interrupt ----------------
`ifdef INT_COALESCE_EN
  localparam int TW = $clog2(COALESCE_TIMEOUT + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          pending;

  // An event in flight between FIFO and evt_data still counts as pending,
  // otherwise the ISSUE/WAIT window would briefly drop irq and the timer.
  assign pending = !bus.fifo_empty || evt_valid_q ||
                   (state_q == RD_ISSUE) || (state_q == RD_WAIT);

  always_comb begin
    timer_d = timer_q;
    if (!pending) begin
      timer_d = '0;
    end else if (timer_q != TW'(COALESCE_TIMEOUT)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Comparing timer_d lets irq rise exactly COALESCE_TIMEOUT cycles after
  // work first becomes pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      if (!pending) begin
        irq_q <= 1'b0;
      end else if (bus.fifo_wmark || (timer_d == TW'(COALESCE_TIMEOUT))) begin
        irq_q <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout = COALESCE_TIMEOUT;
  logic unused_wmark;
  assign unused_wmark = bus.fifo_wmark;

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= evt_valid_q | !bus.fifo_empty;
    end
  end
`endif

endmodule

// File: tb/tb_int_event_scheduler.sv
// tb_int_event_scheduler: directed bench for int_event_scheduler with a
// queue-based FIFO model (one output register, matching RD_LAT=2).
module tb_int_event_scheduler;
  import int_event_sched_pkg::*;

  localparam int NR  = 4;
  localparam int CW  = 6;
  localparam int FWT = 8;

  localparam logic [FWT-1:0] ORDER_DAT [4] = '{8'h01, 8'h42, 8'h83, 8'hC4};
  localparam logic [NR-1:0]  RR_ACK    [6] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
  localparam logic [FWT-1:0] RR_DAT    [6] = '{8'h89, 8'h05, 8'h89, 8'h05, 8'h89, 8'h05};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic force_full  = 1'b0;
  logic force_wmark = 1'b0;

  int checks   = 0;
  int failures = 0;

  int_event_scheduler_if #(.NUM_REQ(NR), .CODE_WIDTH(CW)) bus ();

  int_event_scheduler #(
    .NUM_REQ(NR), .CODE_WIDTH(CW), .RD_LAT(2), .COALESCE_TIMEOUT(15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ---------------- FIFO model ----------------
  logic [FWT-1:0] fq [$];
  int             fcnt = 0;
  logic [FWT-1:0] rd_q = '0;

  always @(posedge clock) begin
    if (reset) begin
      fq.delete();
      fcnt <= 0;
      rd_q <= '0;
    end else begin
      if (bus.fifo_rdEn && fq.size() > 0) rd_q <= fq.pop_front();
      if (bus.fifo_wrEn) fq.push_back(bus.fifo_wrData);
      fcnt <= fq.size();
    end
  end

  assign bus.fifo_empty  = (fcnt == 0);
  assign bus.fifo_full   = force_full;
  assign bus.fifo_wmark  = force_wmark;
  assign bus.fifo_rdData = rd_q;

  // Pops everything the scheduler presents until it has been quiet 4 cycles.
  task automatic drain();
    int idle = 0;
    int n = 0;
    while (idle < 4 && n < 400) begin
      @(negedge clock);
      n++;
      bus.evt_pop = bus.evt_valid;
      if (!bus.evt_valid && bus.fifo_empty && !bus.fifo_rdEn && bus.evt_req == '0) idle++;
      else idle = 0;
    end
    bus.evt_pop = 1'b0;
    checks++;
    if (idle < 4) begin
      failures++;
      $display("FAIL drain: quiet_cycles=%0d required=4 within 400 cycles", idle);
    end
  endtask

  task automatic test_reset();
    bus.evt_req  = 4'hF;
    bus.evt_code = {6'd4, 6'd3, 6'd2, 6'd1};
    bus.evt_pop  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus.evt_ack !== 4'b0)  begin failures++; $display("FAIL reset_ack: got %b expected 0000", bus.evt_ack); end
    checks++; if (bus.fifo_wrEn !== 1'b0) begin failures++; $display("FAIL reset_wrEn: got %b expected 0", bus.fifo_wrEn); end
    checks++; if (bus.fifo_rdEn !== 1'b0) begin failures++; $display("FAIL reset_rdEn: got %b expected 0", bus.fifo_rdEn); end
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.evt_valid); end
    checks++; if (bus.evt_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", bus.evt_data); end
    checks++; if (bus.irq !== 1'b0)       begin failures++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    bus.evt_req = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_order();
    int n;
    @(negedge clock);
    bus.evt_code = {6'd4, 6'd3, 6'd2, 6'd1};
    bus.evt_req  = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.evt_ack !== (4'b0001 << k)) begin failures++; $display("FAIL order_ack[%0d]: got %b expected %b", k, bus.evt_ack, 4'b0001 << k); end
      checks++; if (bus.fifo_wrEn !== 1'b1) begin failures++; $display("FAIL order_wrEn[%0d]: got %b expected 1", k, bus.fifo_wrEn); end
      checks++; if (bus.fifo_wrData !== ORDER_DAT[k]) begin failures++; $display("FAIL order_wrData[%0d]: got %h expected %h", k, bus.fifo_wrData, ORDER_DAT[k]); end
      @(posedge clock); #1;
      bus.evt_req = bus.evt_req & ~(4'b0001 << k);
      @(negedge clock);
    end
    checks++; if (bus.fifo_wrEn !== 1'b0) begin failures++; $display("FAIL order_idle_wrEn: got %b expected 0", bus.fifo_wrEn); end
`ifndef INT_COALESCE_EN
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL order_irq_high: got %b expected 1", bus.irq); end
`endif
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus.evt_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL order_valid_timeout[%0d]: got %b expected 1", k, bus.evt_valid); end
      checks++; if (bus.evt_data !== ORDER_DAT[k]) begin failures++; $display("FAIL order_rd_data[%0d]: got %h expected %h", k, bus.evt_data, ORDER_DAT[k]); end
      bus.evt_pop = 1'b1;
      @(negedge clock);
      bus.evt_pop = 1'b0;
    end
    repeat (4) @(negedge clock);
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL order_end_valid: got %b expected 0", bus.evt_valid); end
`ifndef INT_COALESCE_EN
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL order_irq_low: got %b expected 0", bus.irq); end
`endif
  endtask

  task automatic test_rr_fairness();
    @(negedge clock);
    bus.evt_code = {6'd0, 6'd9, 6'd0, 6'd5};
    bus.evt_req  = 4'b0100;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.evt_ack !== RR_ACK[k]) begin failures++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, bus.evt_ack, RR_ACK[k]); end
      checks++; if (bus.fifo_wrData !== RR_DAT[k]) begin failures++; $display("FAIL rr_data[%0d]: got %h expected %h", k, bus.fifo_wrData, RR_DAT[k]); end
      @(posedge clock); #1;
      if (k == 5) bus.evt_req = '0;
      else if (k % 2 == 0) bus.evt_req = 4'b0101;
      else bus.evt_req = 4'b0100;
      @(negedge clock);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    int bad = 0;
    @(negedge clock);
    force_full   = 1'b1;
    bus.evt_code = {6'd0, 6'd0, 6'd3, 6'd0};
    bus.evt_req  = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.evt_ack !== 4'b0 || bus.fifo_wrEn !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_hold: cycles_with_ack=%0d expected 0", bad); end
    force_full = 1'b0;
    #1;
    checks++; if ({bus.evt_ack, bus.fifo_wrEn} !== 5'b0010_1) begin failures++; $display("FAIL full_release_ack: got %b/%b expected 0010/1", bus.evt_ack, bus.fifo_wrEn); end
    checks++; if (bus.fifo_wrData !== 8'h43) begin failures++; $display("FAIL full_release_data: got %h expected 43", bus.fifo_wrData); end
    @(posedge clock); #1;
    bus.evt_req = '0;
    drain();
  endtask

  task automatic test_read_latency();
    int bad = 0;
    @(negedge clock);
    bus.evt_code = {6'd5, 6'd0, 6'd0, 6'd0};
    bus.evt_req  = 4'b1000;
    #1;
    checks++; if (bus.evt_ack !== 4'b1000) begin failures++; $display("FAIL lat_ack: got %b expected 1000", bus.evt_ack); end
    @(posedge clock); #1;
    bus.evt_req = '0;
    @(negedge clock);
    checks++; if (bus.fifo_rdEn !== 1'b0) begin failures++; $display("FAIL lat_rdEn_s1: got %b expected 0", bus.fifo_rdEn); end
    @(negedge clock);
    checks++; if (bus.fifo_rdEn !== 1'b1) begin failures++; $display("FAIL lat_rdEn_s2: got %b expected 1", bus.fifo_rdEn); end
    @(negedge clock);
    checks++; if ({bus.fifo_rdEn, bus.evt_valid} !== 2'b00) begin failures++; $display("FAIL lat_s3: rdEn/valid got %b expected 00", {bus.fifo_rdEn, bus.evt_valid}); end
    @(negedge clock);
    checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL lat_valid_s4: got %b expected 1", bus.evt_valid); end
    checks++; if (bus.evt_data !== 8'hC5) begin failures++; $display("FAIL lat_data_s4: got %h expected c5", bus.evt_data); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.fifo_rdEn !== 1'b0 || bus.evt_valid !== 1'b1 || bus.evt_data !== 8'hC5) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL lat_hold_stable: bad_cycles=%0d expected 0", bad); end
    bus.evt_pop = 1'b1;
    @(negedge clock);
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL lat_pop_clear: got %b expected 0", bus.evt_valid); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.evt_valid !== 1'b0 || bus.fifo_rdEn !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL lat_pop_ignored: bad_cycles=%0d expected 0", bad); end
    bus.evt_pop = 1'b0;
  endtask

`ifdef INT_COALESCE_EN
  task automatic test_coalesce();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL coal_idle: got %b expected 0", bus.irq); end
    @(negedge clock);
    bus.evt_code = {6'd0, 6'd0, 6'd0, 6'd1};
    bus.evt_req  = 4'b0001;
    @(posedge clock); #1;
    bus.evt_req = '0;
    repeat (15) @(negedge clock);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL coal_timer_early: got %b expected 0", bus.irq); end
    @(negedge clock);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL coal_timer_fire: got %b expected 1", bus.irq); end
    drain();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL coal_timer_clear: got %b expected 0", bus.irq); end
    @(negedge clock);
    bus.evt_req = 4'b0001;
    @(posedge clock); #1;
    bus.evt_req = '0;
    @(negedge clock);
    force_wmark = 1'b1;
    #1;
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL coal_wmark_early: got %b expected 0", bus.irq); end
    @(negedge clock);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL coal_wmark_fire: got %b expected 1", bus.irq); end
    force_wmark = 1'b0;
    drain();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL coal_wmark_clear: got %b expected 0", bus.irq); end
  endtask
`else
  task automatic test_irq_level();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_idle: got %b expected 0", bus.irq); end
    @(negedge clock);
    bus.evt_code = {6'd0, 6'd0, 6'd0, 6'd1};
    bus.evt_req  = 4'b0001;
    @(posedge clock); #1;
    bus.evt_req = '0;
    @(negedge clock);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_s1: got %b expected 0", bus.irq); end
    @(negedge clock);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_s2: got %b expected 1", bus.irq); end
    drain();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_cleared: got %b expected 0", bus.irq); end
  endtask
`endif

  task automatic test_reset_mid_read();
    int bad = 0;
    @(negedge clock);
    bus.evt_code = {6'd0, 6'd0, 6'd7, 6'd0};
    bus.evt_req  = 4'b0010;
    #1;
    checks++; if (bus.fifo_wrData !== 8'h47) begin failures++; $display("FAIL rmr_wrData: got %h expected 47", bus.fifo_wrData); end
    @(posedge clock); #1;
    bus.evt_req = '0;
    repeat (2) @(negedge clock);
    checks++; if (bus.fifo_rdEn !== 1'b1) begin failures++; $display("FAIL rmr_rdEn: got %b expected 1", bus.fifo_rdEn); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({bus.evt_ack, bus.fifo_wrEn, bus.fifo_rdEn} !== 6'b0) begin failures++; $display("FAIL rmr_strobes: got %b expected 000000", {bus.evt_ack, bus.fifo_wrEn, bus.fifo_rdEn}); end
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL rmr_valid: got %b expected 0", bus.evt_valid); end
    checks++; if (bus.evt_data !== 8'h00) begin failures++; $display("FAIL rmr_data: got %h expected 00", bus.evt_data); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL rmr_irq: got %b expected 0", bus.irq); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.evt_valid !== 1'b0 || bus.fifo_rdEn !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rmr_no_spurious: bad_cycles=%0d expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_rr_fairness();
    test_fifo_full();
    test_read_latency();
`ifdef INT_COALESCE_EN
    test_coalesce();
`else
    test_irq_level();
`endif
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/int_event_scheduler.md
INT_EVENT_SCHEDULER -- requirements
Module: int_event_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of interrupt-event requesters (2..8).
REQ-002 SHALL have parameter CODE_WIDTH, default 6, per-requester event code width.
REQ-003 SHALL have parameter RD_LAT, default 2, interrupt-FIFO read latency in cycles (1..3).
REQ-004 SHALL have parameter COALESCE_TIMEOUT, default 255, coalescing timer limit in cycles.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 evt_req  in  NUM_REQ  per-requester event pending; held until acked.
REQ-009 evt_code  in  NUM_REQ*CODE_WIDTH  per-requester code, requester i at slice i.
REQ-010 evt_ack  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-011 fifo_wrEn / fifo_wrData  out  1 / FW  FIFO write strobe and data; FW = CODE_WIDTH + IDW, IDW = clog2(NUM_REQ).
REQ-012 fifo_rdEn  out  1  FIFO read strobe; fifo_rdData  in  FW.
REQ-013 fifo_full, fifo_empty, fifo_wmark  in  1  FIFO status flags.
REQ-014 evt_valid / evt_data  out  1 / FW  event presented to host; evt_pop  in  1  host consumes event.
REQ-015 irq  out  1  level interrupt to host.

Function
REQ-016 Write side SHALL grant round-robin among asserted evt_req, starting after last granted index; after reset the priority pointer is 0.
REQ-017 A grant SHALL occur only when fifo_full=0; fifo_wrEn, evt_ack[i] assert in the same cycle (combinational from registered pointer), at most one write per cycle.
REQ-018 fifo_wrData SHALL be {i[IDW-1:0], evt_code slice i}.
REQ-019 fifo_full=1 SHALL hold all acks low; requests stay pending, no loss, no overwrite.
REQ-020 Read FSM states IDLE, ISSUE, WAIT, HOLD; IDLE->ISSUE when fifo_empty=0 and evt_valid=0.
REQ-021 ISSUE SHALL assert fifo_rdEn for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL count so fifo_rdData is captured into evt_data exactly RD_LAT cycles after the rdEn cycle; evt_valid sets then, state->HOLD.
REQ-023 HOLD SHALL keep evt_data stable until evt_pop=1; then evt_valid clears next cycle, state->IDLE.
REQ-024 evt_pop while evt_valid=0 SHALL be ignored.
REQ-025 Simultaneous write and rdEn SHALL both proceed; FIFO count bookkeeping is the FIFO's.
REQ-026 Without coalescing, irq SHALL equal registered (evt_valid | !fifo_empty).

Reset
REQ-027 On reset: evt_ack=0, fifo_wrEn=0, fifo_rdEn=0, evt_valid=0, evt_data=0, irq=0, FSM=IDLE, RR pointer=0, timer=0.
REQ-028 Reset mid-read (ISSUE/WAIT) SHALL discard the in-flight read; the FIFO is reset alongside.

Configuration
REQ-029 Macro INT_COALESCE_EN: when defined, irq asserts only when fifo_wmark=1 or timer reaches COALESCE_TIMEOUT; timer (clog2(COALESCE_TIMEOUT+1) bits, saturating) counts while fifo_empty=0 or evt_valid=1, clears when both empty/invalid; irq deasserts only when FIFO empty and evt_valid=0.
REQ-030 When undefined, no timer logic; irq per REQ-026.

Structure
REQ-031 Package int_event_sched_pkg SHALL hold FSM state typedef, IDW/FW width functions, default parameter constants.
REQ-032 Round-robin grant SHALL be sub-module int_rr_arbiter (req, enable, grant one-hot, pointer update).

Verification
REQ-033 All 4 requesters assert once, codes 1,2,3,4, FIFO empty -> acks on 4 consecutive cycles order 0,1,2,3; host reads data 0x01,0x42,0x83,0xC4.
REQ-034 Requester 2 held high continuously, requester 0 pulses -> grants alternate 2,0,2; no starvation.
REQ-035 fifo_full=1 for 10 cycles with req 1 pending -> no ack, no wrEn; ack within 1 cycle of fifo_full=0.
REQ-036 RD_LAT=2, one event queued -> fifo_rdEn single cycle, evt_valid exactly 2 cycles later; evt_pop withheld 20 cycles -> evt_data stable, no further rdEn.
REQ-037 INT_COALESCE_EN, COALESCE_TIMEOUT=15, one event below watermark -> irq rises 15 cycles after fifo_empty falls; fifo_wmark=1 -> irq next cycle.
REQ-038 Reset asserted during WAIT -> all outputs to REQ-027 values next cycle; no spurious evt_valid.
